// File: rtl/axi_lite_imem_multiport_if.sv
// AXI4-Lite bus bundle for the instruction memory's PS load/readback port.
interface axi_lite_imem_multiport_if #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_imem_multiport.sv
// Multi-port instruction memory: AXI4-Lite load/readback port, NUM_CORES registered
// fetch ports, and a control window with per-core hold bits and a RAM write counter.
module axi_lite_imem_multiport #(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          DEPTH              = 1024,
  parameter int          NUM_CORES          = 2,
  parameter int          C_S_AXI_ADDR_WIDTH = $clog2(DEPTH*4) + 1,
  parameter logic [31:0] NOP_WORD           = 32'h0000_0013
) (
  input  logic                     S_AXI_ACLK,
  input  logic                     S_AXI_ARESETN,
  axi_lite_imem_multiport_if.slave s_axi,
  input  logic [NUM_CORES-1:0]     fetch_en,
  input  logic [NUM_CORES*32-1:0]  fetch_addr,
  output logic [NUM_CORES*32-1:0]  fetch_data,
  output logic [NUM_CORES-1:0]     fetch_valid,
  output logic [NUM_CORES-1:0]     fetch_err,
  output logic [NUM_CORES-1:0]     core_hold
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int WA = $clog2(DEPTH);
  localparam logic [1:0]    RESP_OKAY   = 2'b00;
  localparam logic [1:0]    RESP_SLVERR = 2'b10;
  localparam logic [WA-1:0] OFF_CTRL    = WA'(0);
  localparam logic [WA-1:0] OFF_WCOUNT  = WA'(1);
  localparam logic [WA-1:0] OFF_INFO    = WA'(2);
  localparam logic [DW-1:0] INFO_WORD   = DW'({8'(NUM_CORES), 24'(DEPTH)});
  localparam logic [31:0]   FETCH_LIMIT = 32'(DEPTH*4);

  typedef enum logic       {W_IDLE, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;

  // Asynchronous assertion, release synchronised to S_AXI_ACLK.
  logic rst_meta_n, rst_n;
  // NOTE: every clocked block uses <= so all flops sample pre-edge values, regardless of block order.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rst_meta_n <= 1'b0;
      rst_n      <= 1'b0;
    end else begin
      rst_meta_n <= 1'b1;
      rst_n      <= rst_meta_n;
    end
  end

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;
  logic                 wr_fire, rd_fire;
  logic                 wr_ctl, rd_ctl_q;
  logic [WA-1:0]        wr_word, rd_word_q;
  logic [1:0]           bresp_q, rresp_q;
  logic [DW-1:0]        rdata_q, wcount_q;
  logic [NUM_CORES-1:0] hold_q;
  logic                 unused_addr_bits;

  assign wr_ctl           = s_axi.awaddr[AW-1];
  assign wr_word          = s_axi.awaddr[AW-2:2];
  assign unused_addr_bits = ^{s_axi.awaddr[1:0], s_axi.araddr[1:0]};

  logic [DW-1:0] mem [DEPTH];

  // NOTE: the RAM array has no reset; clearing it would forbid block-RAM mapping and it holds no control state.
  always_ff @(posedge S_AXI_ACLK) begin
    if (wr_fire && !wr_ctl) begin
      for (int b = 0; b < DW/8; b++)
        if (s_axi.wstrb[b]) mem[wr_word][8*b +: 8] <= s_axi.wdata[8*b +: 8];
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    w_next        = w_state;
    wr_fire       = 1'b0;
    s_axi.awready = 1'b0;
    s_axi.wready  = 1'b0;
    s_axi.bvalid  = 1'b0;
    case (w_state)
      W_IDLE: if (s_axi.awvalid && s_axi.wvalid) begin
        wr_fire       = 1'b1;
        s_axi.awready = 1'b1;
        s_axi.wready  = 1'b1;
        w_next        = W_RESP;
      end
      W_RESP: begin
        s_axi.bvalid = 1'b1;
        if (s_axi.bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_next        = r_state;
    rd_fire       = 1'b0;
    s_axi.arready = 1'b0;
    s_axi.rvalid  = 1'b0;
    case (r_state)
      R_IDLE: if (s_axi.arvalid) begin
        rd_fire       = 1'b1;
        s_axi.arready = 1'b1;
        r_next        = R_WAIT;
      end
      R_WAIT: r_next = R_DATA;
      R_DATA: begin
        s_axi.rvalid = 1'b1;
        if (s_axi.rready) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge rst_n) begin
    if (!rst_n) begin
      w_state   <= W_IDLE;
      r_state   <= R_IDLE;
      bresp_q   <= RESP_OKAY;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      wcount_q  <= '0;
      hold_q    <= '1;
      rd_ctl_q  <= 1'b0;
      rd_word_q <= '0;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
      if (wr_fire) begin
        bresp_q <= RESP_OKAY;
        if (!wr_ctl) begin
          if (wcount_q != '1) wcount_q <= wcount_q + DW'(1);
        end else begin
          case (wr_word)
            OFF_CTRL:   hold_q   <= s_axi.wdata[NUM_CORES-1:0];
            OFF_WCOUNT: wcount_q <= '0;
            OFF_INFO:   bresp_q  <= RESP_OKAY;
            default:    bresp_q  <= RESP_SLVERR;
          endcase
        end
      end
      if (rd_fire) begin
        rd_ctl_q  <= s_axi.araddr[AW-1];
        rd_word_q <= s_axi.araddr[AW-2:2];
      end
      // The RAM read happens in R_WAIT; RDATA then stays frozen through R_DATA.
      if (r_state == R_WAIT) begin
        rresp_q <= RESP_OKAY;
        if (!rd_ctl_q) begin
          rdata_q <= mem[rd_word_q];
        end else begin
          case (rd_word_q)
            OFF_CTRL:   rdata_q <= DW'(hold_q);
            OFF_WCOUNT: rdata_q <= wcount_q;
            OFF_INFO:   rdata_q <= INFO_WORD;
            default: begin
              rdata_q <= '0;
              rresp_q <= RESP_SLVERR;
            end
          endcase
        end
      end
    end
  end

  assign s_axi.bresp = bresp_q;
  assign s_axi.rresp = rresp_q;
  assign s_axi.rdata = rdata_q;
  assign core_hold   = hold_q;

  // Fetch ports read the RAM with plain registered reads, so a same-edge write is seen next access.
  for (genvar i = 0; i < NUM_CORES; i++) begin : g_fetch
    logic [31:0] f_addr;
    logic        f_fault;
    logic [31:0] f_data_q;
    logic        f_valid_q, f_err_q;

    assign f_addr  = fetch_addr[32*i +: 32];
    assign f_fault = (f_addr[1:0] != 2'b00) || (f_addr >= FETCH_LIMIT);

    always_ff @(posedge S_AXI_ACLK or negedge rst_n) begin
      if (!rst_n) begin
        f_valid_q <= 1'b0;
        f_err_q   <= 1'b0;
        f_data_q  <= '0;
      end else begin
        f_valid_q <= fetch_en[i];
        f_err_q   <= fetch_en[i] && f_fault;
        if (fetch_en[i]) f_data_q <= f_fault ? NOP_WORD : mem[f_addr[WA+1:2]];
      end
    end

    assign fetch_data[32*i +: 32] = f_data_q;
    assign fetch_valid[i]         = f_valid_q;
    assign fetch_err[i]           = f_err_q;
  end
endmodule

// File: doc/axi_lite_imem_multiport.md
Name: axi_lite_imem_multiport

Overview:
- Parametrised instruction memory for the multi-core RISC-V/NPU system.
- The PS loads and reads back program words through an AXI4-Lite slave port.
- NUM_CORES independent fetch ports give single-cycle registered instruction reads.
- A control window holds each core in stall until its program is loaded, and counts words written.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI data width and instruction width; only 32 supported.
DEPTH, 1024, number of 32-bit words; power of two, 16..65536.
NUM_CORES, 2, number of fetch ports, 1..8.
C_S_AXI_ADDR_WIDTH, clog2(DEPTH*4)+1, byte address width; the MSB selects the control window.
NOP_WORD, 32'h00000013, word returned on a faulting fetch.

Ports:
S_AXI_ACLK  in  1  clock
S_AXI_ARESETN  in  1  asynchronous active-low reset
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  AW handshake
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte enables
S_AXI_WVALID / S_AXI_WREADY  in/out  1  W handshake
S_AXI_BRESP  out  2  write response
S_AXI_BVALID / S_AXI_BREADY  out/in  1  B handshake
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  AR handshake
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID / S_AXI_RREADY  out/in  1  R handshake
fetch_en  in  NUM_CORES  per-core fetch request
fetch_addr  in  NUM_CORES*32  per-core byte address, core i at [32i+31:32i]
fetch_data  out  NUM_CORES*32  per-core instruction
fetch_valid  out  NUM_CORES  fetch_data valid, one-cycle pulse
fetch_err  out  NUM_CORES  fault flag, coincident with fetch_valid
core_hold  out  NUM_CORES  per-core stall request

Behaviour:
- Reset (async assert, sync release): all AXI READY/VALID outputs 0, BRESP/RRESP 0, RDATA 0, fetch_valid 0, fetch_err 0, fetch_data 0, core_hold all 1s, write counter 0. RAM contents are not reset.
- Write FSM, states W_IDLE -> W_RESP:
  - In W_IDLE, AWREADY and WREADY are 0 until AWVALID and WVALID are both 1. Both READYs then pulse together for one cycle and the write commits that edge under WSTRB.
  - The block moves to W_RESP and asserts BVALID the next cycle, holding it until BREADY.
  - A lone AWVALID or lone WVALID waits; nothing is consumed.
- Read FSM, states R_IDLE -> R_WAIT -> R_DATA:
  - ARREADY pulses one cycle on ARVALID in R_IDLE.
  - R_WAIT absorbs the one-cycle RAM latency.
  - R_DATA holds RVALID and RDATA stable until RREADY, then returns to R_IDLE. Minimum latency from ARVALID&ARREADY to RVALID is 2 cycles.
- Write and read FSMs are independent and may be active in the same cycle.
- Address decode, byte addressed, low 2 bits ignored on AXI:
  - MSB=0: RAM word addr[MSB-1:2].
  - MSB=1: control window.
    - Offset 0x0 CTRL (RW): bits[NUM_CORES-1:0] drive core_hold directly; upper bits read 0.
    - Offset 0x4 WCOUNT (RO): counts committed RAM writes, saturating at 2^32-1. Any write to 0x4 clears it and returns OKAY.
    - Offset 0x8 INFO (RO): {8'(NUM_CORES), 24'(DEPTH)}.
    - Any other offset: RRESP/BRESP = SLVERR (2'b10), RDATA 0, no state change.
- Fetch port i:
  - When fetch_en[i] is sampled 1, fetch_valid[i] and fetch_data[i] are registered on the next edge (latency 1), with fetch_valid 0 otherwise. fetch_data holds its last value when not enabled.
  - Fault when fetch_addr[1:0] != 0 or fetch_addr >= DEPTH*4: fetch_data = NOP_WORD and fetch_err = 1, both with fetch_valid.
  - All cores may fetch every cycle, same or different addresses; no arbitration, no stall.
  - core_hold does not gate fetches; cores obey it themselves.
- Collision (AXI write to word W while any fetch or AXI read of W is in the same cycle): the read returns the old contents (read-first). The new value is visible from the next access.
- Reset asserted mid-transaction: the in-flight transaction is dropped, FSMs return to IDLE, no BVALID/RVALID is produced, and the RAM keeps any write already committed.

Test Plan:
- Release reset, read CTRL at 0x...0 with MSB set -> RDATA = 32'h3 (NUM_CORES=2), core_hold = 2'b11; read INFO -> 32'h02000400.
- AXI writes of 1,2,3,4 to 0x0,0x4,0x8,0xC -> four BRESP=OKAY; read back 1,2,3,4; WCOUNT = 4.
- Write 0xAABBCCDD to 0x10, then write 0x00001100 to 0x10 with WSTRB=4'b0010 -> read 0x10 = 0xAABB11DD.
- Both cores fetch 0x4 and 0x8 the same cycle -> next cycle fetch_valid=2'b11, data 2 and 3, fetch_err=0. Core 1 fetches 0x1000 (=DEPTH*4) -> data 0x00000013, fetch_err[1]=1.
- AXI write 0x55 to 0x0 in the same cycle core 0 fetches 0x0 -> fetch returns 1; the fetch on the next cycle returns 0x55.
- Read control offset 0xC -> RRESP=SLVERR, RDATA 0. Drop ARESETN while in R_DATA with RREADY=0 -> RVALID=0 immediately, core_hold=2'b11.
